// File: rtl/shift_seq_ctrl.sv
// Sequencer for a universal shift register: LOAD, WIDTH shifts, then return the word.
// Define SHIFT_SEQ_LOOPBACK_EN to rotate tx back into the register instead of rx.
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] req_word_i,
   input  logic             req_dir_i,
   input  logic             hold_i,
   input  logic             rx_i,
   output logic             tx_o,
   output logic [1:0]       sr_funct_o,
   output logic [WIDTH-1:0] sr_word_o,
   output logic             sr_serial_o,
   input  logic [WIDTH-1:0] sr_q_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] rsp_word_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [1:0] F_NA    = 2'b00;
   localparam logic [1:0] F_LOAD  = 2'b01;
   localparam logic [1:0] F_LEFT  = 2'b10;
   localparam logic [1:0] F_RIGHT = 2'b11;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_word;
   logic             r_dir;

   logic w_accept;
   logic w_last;
   logic w_tx;
   logic w_serial;

   assign w_accept = req_valid_i && (r_state == S_IDLE);
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_tx     = r_dir ? sr_q_i[0] : sr_q_i[WIDTH-1];

`ifdef SHIFT_SEQ_LOOPBACK_EN
   // rotate: the bit leaving one end re-enters the other
   logic w_unused_rx;
   assign w_unused_rx = rx_i;
   assign w_serial    = w_tx;
`else
   assign w_serial = rx_i;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_word  <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_word <= req_word_i;
            r_dir  <= req_dir_i;
         end
         if (r_state == S_LOAD) begin
            r_cnt <= '0;
         end else if (r_state == S_SHIFT && !hold_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (!hold_i && w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (rsp_ready_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = 1'b0;
      busy_o      = 1'b1;
      sr_funct_o  = F_NA;
      sr_word_o   = '0;
      sr_serial_o = 1'b0;
      tx_o        = 1'b0;
      rsp_valid_o = 1'b0;
      rsp_word_o  = '0;
      unique case (r_state)
         S_IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         S_LOAD: begin
            sr_funct_o = F_LOAD;
            sr_word_o  = r_word;
         end
         S_SHIFT: begin
            tx_o        = w_tx;
            sr_serial_o = w_serial;
            if (!hold_i) sr_funct_o = r_dir ? F_RIGHT : F_LEFT;
         end
         S_DONE: begin
            rsp_valid_o = 1'b1;
            rsp_word_o  = sr_q_i;
         end
         default: begin
            busy_o = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with a behavioural universal shift register.
// Expected tx bits and result words go through scoreboard queues.
module tb_shift_seq_ctrl;

   localparam int W = 4;

`ifdef SHIFT_SEQ_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [W-1:0] req_word_i;
   logic         req_dir_i;
   logic         hold_i;
   logic         rx_i;
   logic         tx_o;
   logic [1:0]   sr_funct_o;
   logic [W-1:0] sr_word_o;
   logic         sr_serial_o;
   logic [W-1:0] sr_q_i = '0;
   logic         rsp_valid_o;
   logic         rsp_ready_i;
   logic [W-1:0] rsp_word_o;
   logic         busy_o;

   int tests = 0;
   int fails = 0;

   logic         tx_q[$];
   logic [W-1:0] rsp_q[$];

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_word_i  (req_word_i),
      .req_dir_i   (req_dir_i),
      .hold_i      (hold_i),
      .rx_i        (rx_i),
      .tx_o        (tx_o),
      .sr_funct_o  (sr_funct_o),
      .sr_word_o   (sr_word_o),
      .sr_serial_o (sr_serial_o),
      .sr_q_i      (sr_q_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_word_o  (rsp_word_o),
      .busy_o      (busy_o)
   );

   // external shift register model
   always @(posedge clk) begin
      case (sr_funct_o)
         2'b01:   sr_q_i <= sr_word_o;
         2'b10:   sr_q_i <= {sr_q_i[W-2:0], sr_serial_o};
         2'b11:   sr_q_i <= {sr_serial_o, sr_q_i[W-1:1]};
         default: sr_q_i <= sr_q_i;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rst();
      chk("rst_req_ready", req_ready_o, 1);
      chk("rst_funct", sr_funct_o, 0);
      chk("rst_sr_word", sr_word_o, 0);
      chk("rst_serial", sr_serial_o, 0);
      chk("rst_tx", tx_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_word", rsp_word_o, 0);
      chk("rst_busy", busy_o, 0);
   endtask

   task automatic txn(input logic [W-1:0] word, input logic dir,
                      input logic [W-1:0] rx, input logic [W-1:0] etx,
                      input logic [W-1:0] ersp, input int hold_after,
                      input int hold_n, input int wait_n,
                      input int abort_at);
      int s;
      int h;
      logic exp_tx;
      for (int i = 0; i < W; i++) tx_q.push_back(etx[W-1-i]);
      rsp_q.push_back(LB ? word : ersp);
      req_valid_i = 1'b1;
      req_word_i  = word;
      req_dir_i   = dir;
      #1;
      chk("req_ready_idle", req_ready_o, 1);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      req_word_i  = ~word;
      req_dir_i   = ~dir;
      #1;
      chk("load_funct", sr_funct_o, 2'b01);
      chk("load_word", sr_word_o, word);
      chk("load_busy", busy_o, 1);
      chk("load_req_ready", req_ready_o, 0);
      @(posedge clk); #1;
      s = 0;
      h = 0;
      while (s < W) begin
         hold_i = (s == hold_after) && (h < hold_n);
         rx_i   = rx[W-1-s];
         if (s == abort_at && !hold_i) begin
            rst_n = 1'b0;
            #1;
            chk_rst();
            tx_q.delete();
            rsp_q.delete();
            hold_i = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            #1;
            chk_rst();
            return;
         end
         #1;
         exp_tx = tx_q[0];
         chk("shift_tx", tx_o, exp_tx);
         if (hold_i) begin
            chk("hold_funct", sr_funct_o, 2'b00);
            h++;
         end else begin
            chk("shift_funct", sr_funct_o, dir ? 2'b11 : 2'b10);
            chk("shift_serial", sr_serial_o, LB ? exp_tx : rx_i);
            void'(tx_q.pop_front());
            s++;
         end
         chk("shift_rsp_valid", rsp_valid_o, 0);
         chk("shift_req_ready", req_ready_o, 0);
         @(posedge clk); #1;
      end
      rx_i = 1'b0;
      for (int w = 0; w < wait_n; w++) begin
         hold_i = w[0];
         #1;
         chk("done_rsp_valid", rsp_valid_o, 1);
         chk("done_rsp_word", rsp_word_o, rsp_q[0]);
         chk("done_funct", sr_funct_o, 2'b00);
         chk("done_req_ready", req_ready_o, 0);
         @(posedge clk); #1;
      end
      hold_i      = 1'b0;
      rsp_ready_i = 1'b1;
      #1;
      chk("hs_rsp_valid", rsp_valid_o, 1);
      chk("hs_rsp_word", rsp_word_o, rsp_q[0]);
      @(posedge clk); #1;
      rsp_ready_i = 1'b0;
      void'(rsp_q.pop_front());
      #1;
      chk("post_req_ready", req_ready_o, 1);
      chk("post_busy", busy_o, 0);
      chk("post_rsp_valid", rsp_valid_o, 0);
      chk("post_rsp_word", rsp_word_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      req_valid_i = 1'b0;
      req_word_i  = '0;
      req_dir_i   = 1'b0;
      hold_i      = 1'b0;
      rx_i        = 1'b0;
      rsp_ready_i = 1'b0;
      #1;
      chk_rst();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_rst();
      // LEFT, no hold
      txn(4'b1011, 1'b0, 4'b1101, 4'b1011, 4'b1101, -1, 0, 0, -1);
      // RIGHT, back-to-back
      txn(4'b1011, 1'b1, 4'b1000, 4'b1101, 4'b0001, -1, 0, 0, -1);
      // hold after second shift, slow response
      txn(4'b1011, 1'b0, 4'b1101, 4'b1011, 4'b1101, 2, 3, 5, -1);
      // reset during third shift
      txn(4'b1011, 1'b0, 4'b1101, 4'b1011, 4'b1101, -1, 0, 0, 2);
      txn(4'b0110, 1'b0, 4'b1010, 4'b0110, 4'b1010, -1, 0, 0, -1);
      // rotation-friendly word
      txn(4'b1001, 1'b1, 4'b1001, 4'b1001, 4'b1001, -1, 0, 0, -1);
      txn(4'b0101, 1'b1, 4'b0110, 4'b1010, 4'b0110, 0, 1, 1, -1);
      chk("sb_tx_empty", tx_q.size(), 0);
      chk("sb_rsp_empty", rsp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
